spi_bus_ctrl: RTL and testbench

- Transaction sequencer between the SPI slave byte interface and the shared 8-bit peripheral bus (address decoder, bar LEDs, switches, future memory).
- Parses each received command byte, collects the data byte for writes, and drives address/data/rw plus a bounded access strobe.
- For reads, captures bus data and loads it into the SPI transmit register.
- Replaces the ss_l-edge-driven sequencing with a single-clock, fully synchronous state machine.

---
 rtl/spi_bus_ctrl.sv | 168 ++++++++++++++++
 tb/tb_spi_bus_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_ctrl.sv
// spi_bus_ctrl: sequences SPI command/data bytes into bounded accesses on the
// shared 8-bit peripheral bus, returning read data to the SPI transmit register.
module spi_bus_ctrl #(
  parameter int unsigned WAIT_CYCLES  = 2,   // bus_req cycles per access (1..15)
  parameter int unsigned DATA_TIMEOUT = 255  // max GET_DATA cycles before abort (1..255)
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       ss_l,
  output logic [7:0] tx_byte,
  output logic       tx_load,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_wdata_oe,
  input  logic [7:0] bus_rdata,
  output logic       bus_rw,
  output logic       bus_req,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    WR_ACCESS,
    RD_ACCESS,
    RD_LOAD
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [7:0] TMO_LIMIT = 8'(DATA_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       oe_q, oe_d;
  logic       rw_q, rw_d;
  logic       req_q, req_d;
  logic [7:0] tx_q, tx_d;
  logic       load_q, load_d;
  logic       err_q, err_d;
  logic [3:0] wcnt_q, wcnt_d;   // strobe cycles elapsed in current access
  logic [7:0] tcnt_q, tcnt_d;   // cycles spent waiting for the write data byte
  logic [7:0] tcnt_inc;

  assign tcnt_inc = tcnt_q + 8'd1;

  // State and output registers; synchronous reset overrides any access in flight.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      rw_q    <= 1'b1;
      req_q   <= 1'b0;
      tx_q    <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      rw_q    <= rw_d;
      req_q   <= req_d;
      tx_q    <= tx_d;
      load_q  <= load_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Next-state logic; bus outputs are registered so strobes start the cycle
  // after the triggering byte and last exactly WAIT_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    rw_d    = rw_q;
    req_d   = req_q;
    tx_d    = tx_q;
    load_d  = 1'b0;
    err_d   = 1'b0;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          addr_d = {1'b0, rx_byte[6:0]};
          if (rx_byte[7]) begin
            rw_d    = 1'b1;
            req_d   = 1'b1;
            wcnt_d  = '0;
            state_d = RD_ACCESS;
          end else begin
            tcnt_d  = '0;
            state_d = GET_DATA;
          end
        end
      end

      GET_DATA: begin
        tcnt_d = tcnt_inc;
        if (rx_valid) begin
          wdata_d = rx_byte;
          rw_d    = 1'b0;
          oe_d    = 1'b1;
          req_d   = 1'b1;
          wcnt_d  = '0;
          state_d = WR_ACCESS;
        end else if (ss_l || (tcnt_inc == TMO_LIMIT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end

      WR_ACCESS: begin
        err_d = rx_valid;
        if (wcnt_q == WAIT_LAST) begin
          req_d   = 1'b0;
          oe_d    = 1'b0;
          rw_d    = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end

      RD_ACCESS: begin
        err_d = rx_valid;
        if (wcnt_q == WAIT_LAST) begin
          tx_d    = bus_rdata;
          req_d   = 1'b0;
          load_d  = 1'b1;
          state_d = RD_LOAD;
        end else begin
          wcnt_d = wcnt_q + 4'd1;
        end
      end

      RD_LOAD: begin
        err_d   = rx_valid;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_byte      = tx_q;
  assign tx_load      = load_q;
  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_wdata_oe = oe_q;
  assign bus_rw       = rw_q;
  assign bus_req      = req_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

endmodule

// File: tb/tb_spi_bus_ctrl.sv
// Self-checking bench for spi_bus_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a timeline reference model.
module tb_spi_bus_ctrl;

  localparam int W = 2;
  localparam int T = 8;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0;
  logic       ss_l = 1'b0;
  logic [7:0] bus_rdata = '0;
  logic [7:0] tx_byte, bus_addr, bus_wdata;
  logic       tx_load, bus_wdata_oe, bus_rw, bus_req, busy, err;

  int n_pass = 0;
  int n_total = 0;

  spi_bus_ctrl #(.WAIT_CYCLES(W), .DATA_TIMEOUT(T)) dut (
    .clk(clk), .rst_l(rst_l), .rx_byte(rx_byte), .rx_valid(rx_valid), .ss_l(ss_l),
    .tx_byte(tx_byte), .tx_load(tx_load), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wdata_oe(bus_wdata_oe), .bus_rdata(bus_rdata), .bus_rw(bus_rw),
    .bus_req(bus_req), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst; logic rxv; logic [7:0] rxb; logic ss; logic [7:0] rd;
    logic       req; logic rw; logic oe; logic [7:0] addr; logic [7:0] wd;
    logic [7:0] tx; logic ld; logic bsy; logic er;
  } vec_t;

  function automatic vec_t mk(input logic rst, rxv, input logic [7:0] rxb, input logic ss,
                              input logic [7:0] rd, input logic req, rw, oe,
                              input logic [7:0] addr, wd, tx, input logic ld, bsy, er);
    vec_t v;
    v.rst = rst; v.rxv = rxv; v.rxb = rxb; v.ss = ss; v.rd = rd;
    v.req = req; v.rw = rw; v.oe = oe; v.addr = addr; v.wd = wd;
    v.tx = tx; v.ld = ld; v.bsy = bsy; v.er = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
  endtask

  task automatic chk_all(input string tag, input logic req, rw, oe, input logic [7:0] addr,
                         wd, tx, input logic ld, bsy, er);
    chk({tag, ".bus_req"},      8'(bus_req),      8'(req));
    chk({tag, ".bus_rw"},       8'(bus_rw),       8'(rw));
    chk({tag, ".bus_wdata_oe"}, 8'(bus_wdata_oe), 8'(oe));
    chk({tag, ".bus_addr"},     bus_addr,         addr);
    chk({tag, ".bus_wdata"},    bus_wdata,        wd);
    chk({tag, ".tx_byte"},      tx_byte,          tx);
    chk({tag, ".tx_load"},      8'(tx_load),      8'(ld));
    chk({tag, ".busy"},         8'(busy),         8'(bsy));
    chk({tag, ".err"},          8'(err),          8'(er));
  endtask

  task automatic drv(input logic rst, rxv, input logic [7:0] b, input logic ss,
                     input logic [7:0] rd);
    rst_l = rst; rx_valid = rxv; rx_byte = b; ss_l = ss; bus_rdata = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: each accepted transaction is reduced to a start cycle and
  // a kind; expected outputs are derived from cycle-number windows.
  int         cyc = 0;
  int         m_kind = 0;        // 0 none, 1 write, 2 read
  int         m_acc_start = -100;
  int         m_free_at = 0;     // first cycle the controller is idle again
  int         m_cmd_cyc = 0;
  int         m_err_at = -1;
  bit         m_in_get = 0;
  logic [7:0] m_addr = '0, m_wd = '0, m_tx = '0;

  task automatic model_step(input logic rst, rxv, input logic [7:0] b, input logic ss,
                            input logic [7:0] rd);
    int c;
    c = cyc;
    if (!rst) begin
      m_kind = 0; m_acc_start = -100; m_free_at = 0; m_in_get = 0; m_err_at = -1;
      m_addr = '0; m_wd = '0; m_tx = '0;
    end else if (m_in_get) begin
      if (rxv) begin
        m_wd = b; m_kind = 1; m_acc_start = c + 1; m_free_at = c + 1 + W; m_in_get = 0;
      end else if (ss || (c - m_cmd_cyc == T)) begin
        m_err_at = c + 1; m_in_get = 0;
      end
    end else if (c >= m_free_at) begin
      if (rxv) begin
        m_addr = {1'b0, b[6:0]};
        if (b[7]) begin
          m_kind = 2; m_acc_start = c + 1; m_free_at = c + W + 2;
        end else begin
          m_in_get = 1; m_cmd_cyc = c;
        end
      end
    end else begin
      if (rxv) m_err_at = c + 1;
      if (m_kind == 2 && c == m_acc_start + W - 1) m_tx = rd;
    end
  endtask

  task automatic check_model();
    bit win;
    win = (m_kind != 0) && (cyc >= m_acc_start) && (cyc < m_acc_start + W);
    chk_all($sformatf("rnd%0d", cyc), win, !(win && m_kind == 1), win && m_kind == 1,
            m_addr, m_wd, m_tx, (m_kind == 2) && (cyc == m_acc_start + W),
            m_in_get || (cyc < m_free_at), cyc == m_err_at);
  endtask

  vec_t tbl[13];

  initial begin
    // rst rxv rxb ss rd | req rw oe addr wd tx ld busy err
    tbl[0]  = mk(0, 0, 8'h00, 0, 8'h00,  0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 0, 8'h00, 0, 8'h00,  0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tbl[2]  = mk(1, 1, 8'h04, 0, 8'h00,  0, 1, 0, 8'h04, 8'h00, 8'h00, 0, 1, 0);
    tbl[3]  = mk(1, 1, 8'hA5, 0, 8'h00,  1, 0, 1, 8'h04, 8'hA5, 8'h00, 0, 1, 0);
    tbl[4]  = mk(1, 0, 8'h00, 0, 8'h00,  1, 0, 1, 8'h04, 8'hA5, 8'h00, 0, 1, 0);
    tbl[5]  = mk(1, 0, 8'h00, 0, 8'h3C,  0, 1, 0, 8'h04, 8'hA5, 8'h00, 0, 0, 0);
    tbl[6]  = mk(1, 1, 8'h82, 0, 8'h3C,  1, 1, 0, 8'h02, 8'hA5, 8'h00, 0, 1, 0);
    tbl[7]  = mk(1, 0, 8'h00, 0, 8'h3C,  1, 1, 0, 8'h02, 8'hA5, 8'h00, 0, 1, 0);
    tbl[8]  = mk(1, 0, 8'h00, 0, 8'h3C,  0, 1, 0, 8'h02, 8'hA5, 8'h3C, 1, 1, 0);
    tbl[9]  = mk(1, 0, 8'h00, 0, 8'h3C,  0, 1, 0, 8'h02, 8'hA5, 8'h3C, 0, 0, 0);
    tbl[10] = mk(1, 1, 8'h04, 0, 8'h00,  0, 1, 0, 8'h04, 8'hA5, 8'h3C, 0, 1, 0);
    tbl[11] = mk(1, 0, 8'h00, 1, 8'h00,  0, 1, 0, 8'h04, 8'hA5, 8'h3C, 0, 0, 1);
    tbl[12] = mk(1, 0, 8'h00, 0, 8'h00,  0, 1, 0, 8'h04, 8'hA5, 8'h3C, 0, 0, 0);

    // Directed table: reset, write, read, ss_l abort.
    for (int i = 0; i < 13; i++) begin
      drv(tbl[i].rst, tbl[i].rxv, tbl[i].rxb, tbl[i].ss, tbl[i].rd);
      tick();
      chk_all($sformatf("row%0d", i), tbl[i].req, tbl[i].rw, tbl[i].oe, tbl[i].addr,
              tbl[i].wd, tbl[i].tx, tbl[i].ld, tbl[i].bsy, tbl[i].er);
    end

    // Timeout: GET_DATA lasts T cycles, err follows.
    drv(1, 1, 8'h04, 0, 8'h00); tick();
    chk("tmo.busy0", 8'(busy), 8'd1);
    drv(1, 0, 8'h00, 0, 8'h00);
    for (int j = 1; j < T; j++) begin
      tick();
      chk($sformatf("tmo.busy%0d", j), 8'(busy), 8'd1);
      chk($sformatf("tmo.err%0d", j), 8'(err), 8'd0);
    end
    tick();
    chk("tmo.err", 8'(err), 8'd1);
    chk("tmo.idle", 8'(busy), 8'd0);
    chk("tmo.noreq", 8'(bus_req), 8'd0);
    tick();
    chk("tmo.errdrop", 8'(err), 8'd0);

    // Overrun during a read.
    drv(1, 1, 8'h82, 0, 8'h77); tick();
    chk("ovr.req1", 8'(bus_req), 8'd1);
    drv(1, 1, 8'h55, 0, 8'h77); tick();
    chk("ovr.err", 8'(err), 8'd1);
    chk("ovr.req2", 8'(bus_req), 8'd1);
    drv(1, 0, 8'h00, 0, 8'h77); tick();
    chk("ovr.tx", tx_byte, 8'h77);
    chk("ovr.load", 8'(tx_load), 8'd1);
    chk("ovr.addr", bus_addr, 8'h02);
    chk("ovr.errdrop", 8'(err), 8'd0);
    tick();
    chk("ovr.idle", 8'(busy), 8'd0);
    chk("ovr.wdata", bus_wdata, 8'hA5);

    // Reset in the middle of a write strobe, then a normal read.
    drv(1, 1, 8'h10, 0, 8'h00); tick();
    drv(1, 1, 8'h99, 0, 8'h00); tick();
    chk("rst.req", 8'(bus_req), 8'd1);
    chk("rst.oe", 8'(bus_wdata_oe), 8'd1);
    drv(0, 0, 8'h00, 0, 8'h00); tick();
    chk_all("rst.after", 0, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    drv(1, 1, 8'h83, 0, 8'h5A); tick();
    chk("rst.rdreq", 8'(bus_req), 8'd1);
    chk("rst.rdaddr", bus_addr, 8'h03);
    drv(1, 0, 8'h00, 0, 8'h5A); tick(); tick();
    chk("rst.rdtx", tx_byte, 8'h5A);
    chk("rst.rdload", 8'(tx_load), 8'd1);
    tick();

    // Back-to-back: new read accepted in the first IDLE cycle after a write.
    drv(1, 1, 8'h01, 0, 8'h00); tick();
    drv(1, 1, 8'h11, 0, 8'h00); tick();
    drv(1, 0, 8'h00, 0, 8'h00); tick(); tick();
    chk("b2b.idle", 8'(busy), 8'd0);
    drv(1, 1, 8'h85, 0, 8'hC3); tick();
    chk("b2b.req", 8'(bus_req), 8'd1);
    chk("b2b.addr", bus_addr, 8'h05);
    drv(1, 0, 8'h00, 0, 8'hC3); tick(); tick();
    chk("b2b.tx", tx_byte, 8'hC3);
    chk("b2b.load", 8'(tx_load), 8'd1);
    tick();

    // Randomized traffic against the reference model.
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      logic r_rst, r_rxv, r_ss;
      logic [7:0] r_b, r_rd;
      bit quiet;
      quiet = ((i / 300) % 2) == 1;
      r_rst = (i == 0) || ($urandom_range(0, 299) == 0);
      r_rxv = quiet ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 2) == 0);
      r_ss  = quiet ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0);
      r_b   = 8'($urandom);
      r_rd  = 8'($urandom);
      if (i > 0) check_model();
      drv(!r_rst, r_rxv, r_b, r_ss, r_rd);
      model_step(!r_rst, r_rxv, r_b, r_ss, r_rd);
      tick();
      cyc++;
    end
    check_model();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
